// File: rtl/core_pkg.sv
// Shared types for the multi-cycle RV32 core: sequencer states,
// trap cause codes and the reset instruction encoding.
package core_pkg;

    typedef enum logic [2:0] {
        FETCH,
        DECODE,
        EXEC,
        MEM,
        WB,
        TRAP
    } seq_state_e;

    localparam logic [4:0] CAUSE_IFAULT  = 5'd1;
    localparam logic [4:0] CAUSE_ILLEGAL = 5'd2;
    localparam logic [4:0] CAUSE_LFAULT  = 5'd5;
    localparam logic [4:0] CAUSE_SFAULT  = 5'd7;
    localparam logic [4:0] CAUSE_IRQ     = 5'd11;

    localparam logic [31:0] NOP = 32'h0000_0013;

    function automatic logic [4:0] mem_fault_cause(input logic store);
        return store ? CAUSE_SFAULT : CAUSE_LFAULT;
    endfunction

endpackage

// File: rtl/wait_timer.sv
// Saturating wait counter shared by the fetch and data-memory handshakes.
// expired_o flags that TIMEOUT wait cycles have elapsed; TIMEOUT=0 disables.
module wait_timer #(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clr_i,
    output logic expired_o
);

    localparam int unsigned W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [W-1:0] LIMIT = W'(TIMEOUT);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (cnt_q != LIMIT) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired_o = (TIMEOUT != 0) && (cnt_q == LIMIT);

endmodule

// File: rtl/multicycle_seq.sv
// Multi-cycle sequencer: walks each instruction through fetch, decode,
// exec, mem and writeback, and owns pc, inst, mepc, mcause and instret.
module multicycle_seq
    import core_pkg::*;
#(
    parameter int unsigned     XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter logic [XLEN-1:0] TRAP_VEC = 'h100,
    parameter int unsigned     TIMEOUT  = 15,
    parameter int unsigned     CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst,
    output logic             imem_req,
    output logic [XLEN-1:0]  imem_addr,
    input  logic             imem_ready,
    input  logic [31:0]      imem_rdata,
    output logic [31:0]      inst,
    output logic [XLEN-1:0]  pc,
    input  logic [XLEN-1:0]  next_pc,
    input  logic             is_load,
    input  logic             is_store,
    input  logic             is_writeback,
    input  logic             is_illegal,
    input  logic             is_mret,
    output logic             dmem_req,
    output logic             dmem_we,
    input  logic             dmem_ready,
    output logic             reg_we,
    input  logic             irq,
    input  logic             irq_en,
    output logic [XLEN-1:0]  mepc,
    output logic [4:0]       mcause,
    output logic             retire,
    output logic [CNT_W-1:0] instret
);

    seq_state_e       state_q;
    logic [XLEN-1:0]  pc_q;
    logic [XLEN-1:0]  target_q;
    logic [XLEN-1:0]  mepc_q;
    logic [31:0]      inst_q;
    logic [4:0]       mcause_q;
    logic [CNT_W-1:0] instret_q;
    logic             imem_req_q;
    logic             dmem_req_q;
    logic             dmem_we_q;
    logic             reg_we_q;
    logic             retire_q;
    logic             expired;
    logic             timer_clr;

    // Every waiting state is entered from a cycle with both requests low,
    // so idling the timer on that condition clears it at each state entry.
    assign timer_clr = ~(imem_req_q | dmem_req_q);

    wait_timer #(
        .TIMEOUT(TIMEOUT)
    ) u_wait_timer (
        .clk_i    (clk),
        .rst_ni   (rst),
        .clr_i    (timer_clr),
        .expired_o(expired)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= FETCH;
            pc_q       <= RESET_PC;
            target_q   <= RESET_PC;
            mepc_q     <= '0;
            inst_q     <= NOP;
            mcause_q   <= '0;
            instret_q  <= '0;
            imem_req_q <= 1'b0;
            dmem_req_q <= 1'b0;
            dmem_we_q  <= 1'b0;
            reg_we_q   <= 1'b0;
            retire_q   <= 1'b0;
        end else begin
            reg_we_q <= 1'b0;
            retire_q <= 1'b0;
            unique case (state_q)
                FETCH: begin
                    // Request is raised here only on the first cycle out of reset.
                    if (!imem_req_q) begin
                        imem_req_q <= 1'b1;
                    end else if (imem_ready) begin
                        inst_q     <= imem_rdata;
                        imem_req_q <= 1'b0;
                        state_q    <= DECODE;
                    end else if (expired) begin
                        mcause_q   <= CAUSE_IFAULT;
                        mepc_q     <= pc_q;
                        imem_req_q <= 1'b0;
                        state_q    <= TRAP;
                    end
                end
                DECODE: begin
                    if (is_illegal) begin
                        mcause_q <= CAUSE_ILLEGAL;
                        mepc_q   <= pc_q;
                        state_q  <= TRAP;
                    end else begin
                        state_q <= EXEC;
                    end
                end
                EXEC: begin
                    target_q <= is_mret ? mepc_q : next_pc;
                    if (is_load | is_store) begin
                        dmem_req_q <= 1'b1;
                        dmem_we_q  <= is_store;
                        state_q    <= MEM;
                    end else begin
                        reg_we_q <= is_writeback & ~is_mret;
                        retire_q <= 1'b1;
                        state_q  <= WB;
                    end
                end
                MEM: begin
                    if (dmem_req_q && dmem_ready) begin
                        dmem_req_q <= 1'b0;
                        dmem_we_q  <= 1'b0;
                        reg_we_q   <= is_writeback & ~is_mret;
                        retire_q   <= 1'b1;
                        state_q    <= WB;
                    end else if (expired) begin
                        mcause_q   <= mem_fault_cause(dmem_we_q);
                        mepc_q     <= pc_q;
                        dmem_req_q <= 1'b0;
                        dmem_we_q  <= 1'b0;
                        state_q    <= TRAP;
                    end
                end
                WB: begin
                    pc_q      <= target_q;
                    instret_q <= instret_q + CNT_W'(1);
                    if (irq && irq_en) begin
                        mepc_q   <= target_q;
                        mcause_q <= CAUSE_IRQ;
                        state_q  <= TRAP;
                    end else begin
                        imem_req_q <= 1'b1;
                        state_q    <= FETCH;
                    end
                end
                TRAP: begin
                    pc_q       <= TRAP_VEC;
                    imem_req_q <= 1'b1;
                    state_q    <= FETCH;
                end
                default: begin
                    state_q <= FETCH;
                end
            endcase
        end
    end

    assign imem_req  = imem_req_q;
    assign imem_addr = pc_q;
    assign pc        = pc_q;
    assign inst      = inst_q;
    assign dmem_req  = dmem_req_q;
    assign dmem_we   = dmem_we_q;
    assign reg_we    = reg_we_q;
    assign retire    = retire_q;
    assign mepc      = mepc_q;
    assign mcause    = mcause_q;
    assign instret   = instret_q;

endmodule

// File: tb/tb_multicycle_seq.sv
// Self-checking bench for multicycle_seq: directed scenarios plus a
// randomized instruction stream checked against a per-instruction model.
module tb_multicycle_seq;

    localparam logic [31:0] TV    = 32'h100;
    localparam logic [31:0] NOPV  = 32'h0000_0013;
    localparam logic [6:0]  OP_ALU = 7'h13;
    localparam logic [6:0]  OP_LD  = 7'h03;
    localparam logic [6:0]  OP_ST  = 7'h23;
    localparam logic [6:0]  OP_MRET = 7'h73;
    localparam logic [6:0]  OP_BAD = 7'h00;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic [31:0] inst;
    logic [31:0] pc;
    logic [31:0] next_pc;
    logic        is_load, is_store, is_writeback, is_illegal, is_mret;
    logic        dmem_req, dmem_we, dmem_ready, reg_we;
    logic        irq, irq_en;
    logic [31:0] mepc;
    logic [4:0]  mcause;
    logic        retire;
    logic [31:0] instret;

    int checks = 0;
    int failures = 0;
    int r_cyc, r_dreq, r_we, r_rwe, r_ret;

    always #5 clk = ~clk;

    multicycle_seq dut (
        .clk(clk), .rst(rst),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ready(imem_ready), .imem_rdata(imem_rdata),
        .inst(inst), .pc(pc), .next_pc(next_pc),
        .is_load(is_load), .is_store(is_store),
        .is_writeback(is_writeback), .is_illegal(is_illegal),
        .is_mret(is_mret),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ready(dmem_ready),
        .reg_we(reg_we), .irq(irq), .irq_en(irq_en),
        .mepc(mepc), .mcause(mcause),
        .retire(retire), .instret(instret)
    );

    // Bench-side stand-in for the decode and gen_next_pc blocks.
    assign is_load      = inst[6:0] == OP_LD;
    assign is_store     = inst[6:0] == OP_ST;
    assign is_mret      = inst[6:0] == OP_MRET;
    assign is_illegal   = !(is_load || is_store || is_mret || inst[6:0] == OP_ALU);
    assign is_writeback = (inst[11:7] != 5'd0) && !is_store;
    assign next_pc      = inst[31] ? {23'd0, inst[30:24], 2'b00} : pc + 32'd4;

    function automatic logic [31:0] mk(input logic [6:0] opc, input logic jmp,
                                       input logic [6:0] tgt, input logic [4:0] rd);
        return {jmp, tgt, 12'h000, rd, opc};
    endfunction

    // Drives one instruction from the first requesting fetch cycle up to
    // the first requesting fetch cycle of the next one; counts activity.
    task automatic run_inst(input logic [31:0] ins, input int iw, input int dw,
                            input int ilo, input int ihi, input bit noise);
        int icnt;
        int dcnt;
        bit seen_low;
        bit done;
        icnt = 0; dcnt = 0; seen_low = 0; done = 0;
        r_cyc = 0; r_dreq = 0; r_we = 0; r_rwe = 0; r_ret = 0;
        imem_rdata = ins;
        while (!done && r_cyc < 200) begin
            irq = (r_cyc >= ilo) && (r_cyc <= ihi);
            imem_ready = imem_req ? (icnt >= iw) : (noise && $urandom_range(1) == 1);
            dmem_ready = dmem_req ? (dcnt >= dw) : (noise && $urandom_range(1) == 1);
            if (imem_req) icnt++;
            if (dmem_req) begin
                dcnt++;
                r_dreq++;
                if (dmem_we) r_we++;
            end
            if (reg_we) r_rwe++;
            if (retire) r_ret++;
            @(posedge clk); #1;
            r_cyc++;
            if (!imem_req) seen_low = 1;
            else if (seen_low) done = 1;
        end
        irq = 1'b0;
        imem_ready = 1'b0;
        dmem_ready = 1'b0;
    endtask

    task automatic reset_dut();
        rst = 1'b0;
        irq = 1'b0;
        imem_ready = 1'b0;
        dmem_ready = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst = 1'b0; irq = 1'b0; irq_en = 1'b1;
        imem_ready = 1'b0; dmem_ready = 1'b0; imem_rdata = 32'hdead_beef;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (pc !== 32'h0) begin failures++; $display("FAIL rst_pc got=%h exp=%h", pc, 32'h0); end
        checks++; if (inst !== NOPV) begin failures++; $display("FAIL rst_inst got=%h exp=%h", inst, NOPV); end
        checks++; if (mepc !== 32'h0 || mcause !== 5'd0) begin failures++; $display("FAIL rst_trap got=%h/%0d exp=0/0", mepc, mcause); end
        checks++; if (instret !== 32'h0) begin failures++; $display("FAIL rst_instret got=%0d exp=0", instret); end
        checks++; if ({imem_req, dmem_req, dmem_we, reg_we, retire} !== 5'b0) begin
            failures++; $display("FAIL rst_outs got=%b exp=00000", {imem_req, dmem_req, dmem_we, reg_we, retire});
        end
        rst = 1'b1;
        imem_ready = 1'b1; dmem_ready = 1'b1;
        #1;
        checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL rel_req0 got=%b exp=0", imem_req); end
        @(posedge clk); #1;
        imem_ready = 1'b0; dmem_ready = 1'b0;
        checks++; if (imem_req !== 1'b1) begin failures++; $display("FAIL first_req got=%b exp=1", imem_req); end
        checks++; if (inst !== NOPV) begin failures++; $display("FAIL ready_noreq got=%h exp=%h", inst, NOPV); end
        checks++; if (imem_addr !== 32'h0) begin failures++; $display("FAIL rst_addr got=%h exp=0", imem_addr); end
    endtask

    task automatic test_alu_stream();
        for (int i = 0; i < 3; i++) begin
            run_inst(mk(OP_ALU, 1'b0, 7'd0, 5'd1), 0, 0, 1000, -1, 1'b0);
            checks++; if (r_cyc !== 4) begin failures++; $display("FAIL alu_cycles[%0d] got=%0d exp=4", i, r_cyc); end
            checks++; if (r_ret !== 1 || r_rwe !== 1) begin failures++; $display("FAIL alu_pulses[%0d] got=%0d/%0d exp=1/1", i, r_ret, r_rwe); end
            checks++; if (pc !== 32'(4 * (i + 1))) begin failures++; $display("FAIL alu_pc[%0d] got=%h exp=%h", i, pc, 32'(4 * (i + 1))); end
        end
        checks++; if (instret !== 32'd3) begin failures++; $display("FAIL alu_instret got=%0d exp=3", instret); end
    endtask

    task automatic test_load_wait();
        run_inst(mk(OP_LD, 1'b0, 7'd0, 5'd2), 0, 3, 1000, -1, 1'b0);
        checks++; if (r_dreq !== 4 || r_we !== 0) begin failures++; $display("FAIL ld_dreq got=%0d/%0d exp=4/0", r_dreq, r_we); end
        checks++; if (r_rwe !== 1 || r_ret !== 1) begin failures++; $display("FAIL ld_pulses got=%0d/%0d exp=1/1", r_rwe, r_ret); end
        checks++; if (r_cyc !== 8) begin failures++; $display("FAIL ld_cycles got=%0d exp=8", r_cyc); end
        checks++; if (pc !== 32'h10 || instret !== 32'd4) begin failures++; $display("FAIL ld_state got=%h/%0d exp=10/4", pc, instret); end
    endtask

    task automatic test_illegal();
        run_inst(mk(OP_ALU, 1'b1, 7'd8, 5'd0), 0, 0, 1000, -1, 1'b0);
        checks++; if (pc !== 32'h20 || r_rwe !== 0 || r_ret !== 1) begin
            failures++; $display("FAIL jump_pc got=%h/%0d/%0d exp=20/0/1", pc, r_rwe, r_ret);
        end
        run_inst(mk(OP_BAD, 1'b0, 7'd0, 5'd3), 0, 0, 1000, -1, 1'b0);
        checks++; if (r_cyc !== 3) begin failures++; $display("FAIL ill_cycles got=%0d exp=3", r_cyc); end
        checks++; if (r_ret !== 0 || r_rwe !== 0) begin failures++; $display("FAIL ill_pulses got=%0d/%0d exp=0/0", r_ret, r_rwe); end
        checks++; if (mepc !== 32'h20 || mcause !== 5'd2) begin failures++; $display("FAIL ill_trap got=%h/%0d exp=20/2", mepc, mcause); end
        checks++; if (pc !== TV || instret !== 32'd5) begin failures++; $display("FAIL ill_state got=%h/%0d exp=100/5", pc, instret); end
    endtask

    task automatic test_irq_store();
        run_inst(mk(OP_ALU, 1'b1, 7'd16, 5'd1), 0, 0, 1000, -1, 1'b0);
        checks++; if (pc !== 32'h40) begin failures++; $display("FAIL irq_setup got=%h exp=40", pc); end
        run_inst(mk(OP_ST, 1'b0, 7'd0, 5'd5), 0, 2, 4, 1000, 1'b0);
        checks++; if (r_cyc !== 8) begin failures++; $display("FAIL irq_cycles got=%0d exp=8", r_cyc); end
        checks++; if (r_ret !== 1 || r_rwe !== 0 || r_we !== 3) begin
            failures++; $display("FAIL irq_st_pulses got=%0d/%0d/%0d exp=1/0/3", r_ret, r_rwe, r_we);
        end
        checks++; if (mepc !== 32'h44 || mcause !== 5'd11) begin failures++; $display("FAIL irq_trap got=%h/%0d exp=44/11", mepc, mcause); end
        checks++; if (pc !== TV || instret !== 32'd7) begin failures++; $display("FAIL irq_state got=%h/%0d exp=100/7", pc, instret); end
        run_inst(mk(OP_ALU, 1'b0, 7'd0, 5'd1), 0, 0, 1, 2, 1'b0);
        checks++; if (r_cyc !== 4 || pc !== 32'h104) begin failures++; $display("FAIL irq_drop got=%0d/%h exp=4/104", r_cyc, pc); end
        checks++; if (mepc !== 32'h44 || mcause !== 5'd11) begin failures++; $display("FAIL irq_drop_trap got=%h/%0d exp=44/11", mepc, mcause); end
    endtask

    task automatic test_mret();
        run_inst(mk(OP_MRET, 1'b0, 7'd0, 5'd1), 0, 0, 1000, -1, 1'b0);
        checks++; if (r_cyc !== 4 || r_ret !== 1 || r_rwe !== 0) begin
            failures++; $display("FAIL mret_pulses got=%0d/%0d/%0d exp=4/1/0", r_cyc, r_ret, r_rwe);
        end
        checks++; if (pc !== 32'h44 || instret !== 32'd9) begin failures++; $display("FAIL mret_state got=%h/%0d exp=44/9", pc, instret); end
    endtask

    task automatic test_timeouts();
        reset_dut();
        run_inst(mk(OP_ALU, 1'b0, 7'd0, 5'd1), 1000, 0, 1000, -1, 1'b0);
        checks++; if (r_cyc !== 17 || r_ret !== 0) begin failures++; $display("FAIL ifault_cycles got=%0d/%0d exp=17/0", r_cyc, r_ret); end
        checks++; if (mcause !== 5'd1 || mepc !== 32'h0 || pc !== TV) begin
            failures++; $display("FAIL ifault_trap got=%0d/%h/%h exp=1/0/100", mcause, mepc, pc);
        end
        run_inst(mk(OP_ALU, 1'b0, 7'd0, 5'd1), 15, 0, 1000, -1, 1'b0);
        checks++; if (r_cyc !== 19 || r_ret !== 1 || pc !== 32'h104) begin
            failures++; $display("FAIL ifetch_edge got=%0d/%0d/%h exp=19/1/104", r_cyc, r_ret, pc);
        end
        run_inst(mk(OP_LD, 1'b0, 7'd0, 5'd1), 0, 1000, 1000, -1, 1'b0);
        checks++; if (r_cyc !== 20 || r_dreq !== 16 || r_ret !== 0 || r_rwe !== 0) begin
            failures++; $display("FAIL lfault_cnt got=%0d/%0d/%0d/%0d exp=20/16/0/0", r_cyc, r_dreq, r_ret, r_rwe);
        end
        checks++; if (mcause !== 5'd5 || mepc !== 32'h104 || pc !== TV) begin
            failures++; $display("FAIL lfault_trap got=%0d/%h/%h exp=5/104/100", mcause, mepc, pc);
        end
        run_inst(mk(OP_ST, 1'b0, 7'd0, 5'd0), 0, 1000, 1000, -1, 1'b0);
        checks++; if (mcause !== 5'd7 || mepc !== TV || r_we !== 16) begin
            failures++; $display("FAIL sfault_trap got=%0d/%h/%0d exp=7/100/16", mcause, mepc, r_we);
        end
        run_inst(mk(OP_LD, 1'b0, 7'd0, 5'd1), 0, 15, 1000, -1, 1'b0);
        checks++; if (r_cyc !== 20 || r_ret !== 1 || pc !== 32'h104 || instret !== 32'd2) begin
            failures++; $display("FAIL dmem_edge got=%0d/%0d/%h/%0d exp=20/1/104/2", r_cyc, r_ret, pc, instret);
        end
    endtask

    task automatic test_random();
        logic [31:0] m_pc, m_mepc, m_instret, target, ins;
        logic [4:0]  m_mcause, rd;
        logic [6:0]  opc, tgt;
        logic        jmp;
        int cls, iw, dw, ilo, ihi, wb_idx;
        int e_cyc, e_dreq, e_we, e_rwe, e_ret;
        bit mem, st;
        reset_dut();
        m_pc = 0; m_mepc = 0; m_instret = 0; m_mcause = 0;
        for (int n = 0; n < 60; n++) begin
            cls = $urandom_range(9);
            opc = (cls < 4) ? OP_ALU : (cls < 6) ? OP_LD : (cls < 8) ? OP_ST : (cls == 8) ? OP_MRET : OP_BAD;
            jmp = ($urandom_range(3) == 0);
            tgt = 7'($urandom_range(127));
            rd  = 5'($urandom_range(3));
            ins = mk(opc, jmp, tgt, rd);
            iw  = ($urandom_range(11) == 0) ? 16 + $urandom_range(3) : $urandom_range(3);
            dw  = ($urandom_range(11) == 0) ? 16 + $urandom_range(3) : $urandom_range(3);
            if ($urandom_range(2) == 0) begin
                ilo = $urandom_range(8); ihi = ilo + $urandom_range(6);
            end else begin
                ilo = 1000; ihi = -1;
            end
            irq_en = ($urandom_range(1) == 1);
            mem = (opc == OP_LD) || (opc == OP_ST);
            st  = (opc == OP_ST);
            e_dreq = 0; e_we = 0; e_rwe = 0; e_ret = 0;
            if (iw >= 16) begin
                e_cyc = 17; m_mepc = m_pc; m_mcause = 5'd1; m_pc = TV;
            end else if (opc == OP_BAD) begin
                e_cyc = iw + 3; m_mepc = m_pc; m_mcause = 5'd2; m_pc = TV;
            end else if (mem && dw >= 16) begin
                e_cyc = iw + 20; e_dreq = 16; e_we = st ? 16 : 0;
                m_mepc = m_pc; m_mcause = st ? 5'd7 : 5'd5; m_pc = TV;
            end else begin
                e_cyc = iw + 3;
                if (mem) begin
                    e_cyc += dw + 1; e_dreq = dw + 1; e_we = st ? dw + 1 : 0;
                end
                wb_idx = e_cyc;
                e_cyc++;
                e_ret = 1;
                e_rwe = (rd != 0 && !st && opc != OP_MRET) ? 1 : 0;
                target = (opc == OP_MRET) ? m_mepc : jmp ? {23'd0, tgt, 2'b00} : m_pc + 32'd4;
                m_instret++;
                if (irq_en && ilo <= wb_idx && wb_idx <= ihi) begin
                    e_cyc++; m_mepc = target; m_mcause = 5'd11; m_pc = TV;
                end else begin
                    m_pc = target;
                end
            end
            run_inst(ins, iw, dw, ilo, ihi, ($urandom_range(1) == 1));
            checks++; if (r_cyc !== e_cyc) begin failures++; $display("FAIL rnd_cycles[%0d] got=%0d exp=%0d", n, r_cyc, e_cyc); end
            checks++; if (r_ret !== e_ret || r_rwe !== e_rwe) begin failures++; $display("FAIL rnd_pulses[%0d] got=%0d/%0d exp=%0d/%0d", n, r_ret, r_rwe, e_ret, e_rwe); end
            checks++; if (r_dreq !== e_dreq || r_we !== e_we) begin failures++; $display("FAIL rnd_dmem[%0d] got=%0d/%0d exp=%0d/%0d", n, r_dreq, r_we, e_dreq, e_we); end
            checks++; if (pc !== m_pc || imem_addr !== m_pc) begin failures++; $display("FAIL rnd_pc[%0d] got=%h/%h exp=%h", n, pc, imem_addr, m_pc); end
            checks++; if (mepc !== m_mepc || mcause !== m_mcause) begin failures++; $display("FAIL rnd_trap[%0d] got=%h/%0d exp=%h/%0d", n, mepc, mcause, m_mepc, m_mcause); end
            checks++; if (instret !== m_instret) begin failures++; $display("FAIL rnd_instret[%0d] got=%0d exp=%0d", n, instret, m_instret); end
        end
        irq_en = 1'b1;
    endtask

    task automatic test_reset_mid_mem();
        imem_rdata = mk(OP_LD, 1'b0, 7'd0, 5'd1);
        for (int k = 0; k < 20 && !dmem_req; k++) begin
            imem_ready = imem_req;
            @(posedge clk); #1;
        end
        imem_ready = 1'b0; dmem_ready = 1'b0;
        checks++; if (dmem_req !== 1'b1) begin failures++; $display("FAIL midmem_reach got=%b exp=1", dmem_req); end
        repeat (2) @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        checks++; if ({dmem_req, reg_we, retire} !== 3'b0) begin
            failures++; $display("FAIL midmem_drop got=%b exp=000", {dmem_req, reg_we, retire});
        end
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        checks++; if (pc !== 32'h0 || instret !== 32'h0) begin failures++; $display("FAIL midmem_after got=%h/%0d exp=0/0", pc, instret); end
        checks++; if (imem_req !== 1'b1 || dmem_req !== 1'b0) begin
            failures++; $display("FAIL midmem_req got=%b/%b exp=1/0", imem_req, dmem_req);
        end
    endtask

    initial begin
        test_reset();
        test_alu_stream();
        test_load_wait();
        test_illegal();
        test_irq_store();
        test_mret();
        test_timeouts();
        test_random();
        test_reset_mid_mem();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/multicycle_seq.md
# multicycle_seq

Cycle sequencer for the multi-cycle generation of the RV32 core. It owns the PC, the instruction register, the trap registers (mepc/mcause) and the retired-instruction counter. It steps each instruction through fetch, decode, execute, memory and writeback using ready/req handshakes to instruction and data memory. The existing datapath blocks (gen_next_pc, decode, alu, mem, writeback) remain combinational and are gated by this block's enables.

## Interface
Parameters:
- XLEN, 32: PC/address width.
- RESET_PC, 0: PC value loaded at reset.
- TRAP_VEC, 32'h100: PC on any trap.
- TIMEOUT, 15: maximum wait cycles for imem/dmem ready before an access fault; 0 disables.
- CNT_W, 32: instret counter width.

Ports (name, direction, width, meaning):
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset.
- imem_req  out  1  fetch request, held until accepted.
- imem_addr  out  XLEN  fetch address, always equals pc.
- imem_ready  in  1  fetch data valid this cycle.
- imem_rdata  in  32  fetched instruction.
- inst  out  32  instruction register.
- pc  out  XLEN  current PC.
- next_pc  in  XLEN  from gen_next_pc, valid in EXEC.
- is_load, is_store  in  1  decode class, valid from DECODE onward.
- is_writeback  in  1  instruction writes rd.
- is_illegal  in  1  decode reports an illegal encoding.
- is_mret  in  1  decoded mret.
- dmem_req  out  1  data access request.
- dmem_we  out  1  store qualifier for dmem_req.
- dmem_ready  in  1  data access complete.
- reg_we  out  1  register-file write pulse.
- irq  in  1  level interrupt request.
- irq_en  in  1  global interrupt enable (from csr).
- mepc  out  XLEN  trap return address.
- mcause  out  5  trap cause code.
- retire  out  1  one-cycle pulse per retired instruction.
- instret  out  CNT_W  retired-instruction count.

## Operation
- States: FETCH, DECODE, EXEC, MEM, WB, TRAP.
- **FETCH**
  - imem_req=1.
  - On imem_ready: inst<=imem_rdata, go to DECODE.
  - If the wait count reaches TIMEOUT: mcause=1, mepc=pc, go to TRAP.
- **DECODE**, one cycle.
  - If is_illegal: mcause=2, mepc=pc, go to TRAP.
  - Otherwise go to EXEC.
- **EXEC**, one cycle.
  - Latch target: mepc if is_mret, else next_pc.
  - Go to MEM if is_load|is_store, else go to WB.
- **MEM**
  - dmem_req=1, dmem_we=is_store.
  - On dmem_ready: go to WB.
  - On timeout: mcause=5 (load) or 7 (store), mepc=pc, go to TRAP. No register write occurs.
- **WB**, one cycle.
  - reg_we=is_writeback & ~is_mret.
  - retire=1, instret++ (wraps modulo 2^CNT_W).
  - pc<=latched target.
  - If irq&irq_en: mepc<=latched target, mcause=5'd11 (interrupt flag kept in csr), go to TRAP. Otherwise go to FETCH.
- **TRAP**, one cycle: pc<=TRAP_VEC, go to FETCH. No retire pulse.
- Interrupts are taken only at the WB boundary. An irq arriving mid-instruction waits. An irq deasserted before WB is ignored.
- If a synchronous trap and an irq are pending together, the synchronous trap wins; irq is re-evaluated at the next WB.
- Wait counter clears on every state entry and saturates at TIMEOUT.

## Timing
- Reset values:
  - pc=RESET_PC, inst=32'h00000013 (nop), state=FETCH.
  - mepc=0, mcause=0, instret=0.
  - All req/we/retire outputs 0.
- First imem_req is asserted the first cycle after rst deasserts.
- Latency with zero-wait memory:
  - ALU/jump/branch instructions: 4 cycles.
  - Load/store: 5 cycles.
  - Each wait cycle adds 1.
- imem_req/dmem_req stay high until the cycle ready is sampled, and drop the next cycle.
- Ready sampled while req is low is ignored.
- reg_we and retire are single-cycle pulses, coincident in WB.
- Reset asserted mid-operation aborts immediately, with no partial writeback. A pending req drops asynchronously.

## Structure
- core_pkg holds:
  - the state enum;
  - cause constants: CAUSE_IFAULT=1, CAUSE_ILLEGAL=2, CAUSE_LFAULT=5, CAUSE_SFAULT=7, CAUSE_IRQ=11;
  - the NOP encoding.
- One sub-module, wait_timer: a saturating counter with a clear input and a TIMEOUT parameter, producing an expired flag. It is instantiated once and shared by FETCH and MEM.

## Test plan
- Zero-wait ALU stream, RESET_PC=0, 3 addi instructions:
  - pc goes 0→4→8→12;
  - retire pulses 4 cycles apart;
  - instret=3.
- Load with dmem_ready delayed 3 cycles:
  - dmem_req high for 4 cycles;
  - reg_we one pulse in WB;
  - total 8 cycles.
- imem_ready never asserted, TIMEOUT=15:
  - TRAP on the 16th wait cycle;
  - mcause=1, mepc=0;
  - pc=TRAP_VEC.
- is_illegal in DECODE at pc=0x20:
  - no reg_we, no retire;
  - mepc=0x20, mcause=2.
- irq raised during MEM of a store at pc=0x40, next_pc=0x44:
  - store completes and retires;
  - mepc=0x44, mcause=11;
  - pc=TRAP_VEC.
- rst pulled low during a MEM wait:
  - dmem_req drops at once;
  - after release, pc=RESET_PC and instret=0.
